// File: rtl/jkreg_pkg.sv
// Shared types and limits for the jkreg_bank JK register bank.
package jkreg_pkg;

    // Operation select encoding for the bank
    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_CNT  = 2'b10,
        MODE_SHL  = 2'b11
    } jkreg_mode_t;

    // Largest supported bank width
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK next-state evaluator. Purely combinational; the state
// flop lives in the parent bank.
module jk_cell (
    input  logic j,
    input  logic k,
    input  logic q,
    output logic q_nxt
);

    // j=k=0 holds, j=1 sets, k=1 clears, j=k=1 toggles
    assign q_nxt = (j & ~q) | (~k & q);

endmodule

// File: rtl/jkreg_bank.sv
// jkreg_bank: WIDTH JK cells sharing clock, reset and enable, usable as a
// JK register, parallel-load register, up/down counter or left shifter.
// Build option: define JKREG_SAT_EN to make the counter saturate at
// all-ones / zero instead of wrapping.
module jkreg_bank
    import jkreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;

    jkreg_mode_t      mode_t;
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] shl_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign mode_t = jkreg_mode_t'(mode);

    // Counter step: wraps by default, clamps at the ends when saturation is built in
    function automatic logic [WIDTH-1:0] cnt_step(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
`ifdef JKREG_SAT_EN
        if (up)
            return (cur == ONES) ? cur : cur + ONE;
        else
            return (cur == '0) ? cur : cur - ONE;
`else
        if (up)
            return cur + ONE;
        else
            return cur - ONE;
`endif
    endfunction

    // Per-bit JK next-state evaluators
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .q_nxt (jk_nxt[i])
        );
    end

    // Shift-left next state; a single-bit bank simply takes si
    if (WIDTH == 1) begin : g_shl_one
        assign shl_nxt = si;
    end else begin : g_shl_wide
        assign shl_nxt = {q[WIDTH-2:0], si};
    end

    // Select the next state for the current mode
    always_comb begin
        q_nxt = q;
        unique case (mode_t)
            MODE_JK:   q_nxt = jk_nxt;
            MODE_LOAD: q_nxt = d;
            MODE_CNT:  q_nxt = cnt_step(q, dir);
            MODE_SHL:  q_nxt = shl_nxt;
            default:   q_nxt = q;
        endcase
    end

    // State register: async reset to RESET_VAL, update only when enabled
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= RESET_VAL;
        else if (en)
            q <= q_nxt;
    end

    assign so = q[WIDTH-1];

    // Terminal count looks at the live state and direction, not at en
    assign tc = (mode_t == MODE_CNT) && (dir ? (q == ONES) : (q == '0));

endmodule

// File: tb/tb_jkreg_bank.sv
// Directed testbench for jkreg_bank (WIDTH=8, RESET_VAL=8'hA5).
module tb_jkreg_bank;
    import jkreg_pkg::*;

    logic       clk;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j, k, d;
    logic       dir;
    logic       si;
    logic [7:0] q;
    logic       so;
    logic       tc;

    int checks   = 0;
    int failures = 0;

    jkreg_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .dir  (dir),
        .si   (si),
        .q    (q),
        .so   (so),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        en = 1'b1; mode = MODE_LOAD; d = v;
        step();
    endtask

    task automatic test_reset();
        do_load(8'h3C);
        checks++;
        if (q !== 8'h3C) begin failures++; $display("FAIL reset_preload q=%h exp=%h", q, 8'h3C); end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (q !== 8'hA5) begin failures++; $display("FAIL reset_async q=%h exp=%h", q, 8'hA5); end
        checks++;
        if (so !== 1'b1) begin failures++; $display("FAIL reset_so so=%b exp=1", so); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc tc=%b exp=0", tc); end
        clr = 1'b0; en = 1'b0; d = 8'h00;
        step();
        step();
        checks++;
        if (q !== 8'hA5) begin failures++; $display("FAIL reset_hold q=%h exp=%h", q, 8'hA5); end
    endtask

    task automatic test_jk();
        do_load(8'hF0);
        mode = MODE_JK; j = 8'h0F; k = 8'hFF; d = 8'h55;
        step();
        checks++;
        if (q !== 8'h0F) begin failures++; $display("FAIL jk_clr_toggle q=%h exp=%h", q, 8'h0F); end
        j = 8'hFF; k = 8'hFF;
        step();
        checks++;
        if (q !== 8'hF0) begin failures++; $display("FAIL jk_toggle_all q=%h exp=%h", q, 8'hF0); end
        j = 8'h0C; k = 8'hC0;
        step();
        checks++;
        if (q !== 8'h3C) begin failures++; $display("FAIL jk_set_clr_hold q=%h exp=%h", q, 8'h3C); end
        j = 8'h00; k = 8'h00;
        step();
        checks++;
        if (q !== 8'h3C) begin failures++; $display("FAIL jk_hold q=%h exp=%h", q, 8'h3C); end
    endtask

    task automatic test_count();
        do_load(8'hFE);
        mode = MODE_CNT; dir = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL cnt_tc_fe tc=%b exp=0", tc); end
        step();
        checks++;
        if (q !== 8'hFF || tc !== 1'b1) begin failures++; $display("FAIL cnt_up_ff q=%h tc=%b exp=ff/1", q, tc); end
        step();
`ifdef JKREG_SAT_EN
        checks++;
        if (q !== 8'hFF || tc !== 1'b1) begin failures++; $display("FAIL cnt_up_sat q=%h tc=%b exp=ff/1", q, tc); end
`else
        checks++;
        if (q !== 8'h00 || tc !== 1'b0) begin failures++; $display("FAIL cnt_up_wrap q=%h tc=%b exp=00/0", q, tc); end
`endif
        do_load(8'h01);
        mode = MODE_CNT; dir = 1'b0;
        step();
        checks++;
        if (q !== 8'h00 || tc !== 1'b1) begin failures++; $display("FAIL cnt_dn_00 q=%h tc=%b exp=00/1", q, tc); end
        // Up direction at zero is not terminal
        dir = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL cnt_tc_dir tc=%b exp=0", tc); end
        // tc is zero outside count mode
        mode = MODE_LOAD; dir = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL tc_other_mode tc=%b exp=0", tc); end
        mode = MODE_CNT; dir = 1'b0;
        step();
`ifdef JKREG_SAT_EN
        checks++;
        if (q !== 8'h00 || tc !== 1'b1) begin failures++; $display("FAIL cnt_dn_sat q=%h tc=%b exp=00/1", q, tc); end
`else
        checks++;
        if (q !== 8'hFF || tc !== 1'b0) begin failures++; $display("FAIL cnt_dn_wrap q=%h tc=%b exp=ff/0", q, tc); end
`endif
    endtask

    task automatic test_shift();
        do_load(8'h81);
        mode = MODE_SHL; si = 1'b1;
        #1;
        checks++;
        if (so !== 1'b1) begin failures++; $display("FAIL shl_so_pre so=%b exp=1", so); end
        step();
        checks++;
        if (q !== 8'h03 || so !== 1'b0) begin failures++; $display("FAIL shl_first q=%h so=%b exp=03/0", q, so); end
        si = 1'b0;
        step();
        checks++;
        if (q !== 8'h06) begin failures++; $display("FAIL shl_second q=%h exp=%h", q, 8'h06); end
    endtask

    task automatic test_enable_hold();
        do_load(8'h10);
        mode = MODE_CNT; dir = 1'b1; en = 1'b0;
        for (int n = 0; n < 3; n++) step();
        checks++;
        if (q !== 8'h10) begin failures++; $display("FAIL en_hold q=%h exp=%h", q, 8'h10); end
        en = 1'b1;
        step();
        checks++;
        if (q !== 8'h11) begin failures++; $display("FAIL en_resume q=%h exp=%h", q, 8'h11); end
        #2 clr = 1'b1;
        #1;
        checks++;
        if (q !== 8'hA5) begin failures++; $display("FAIL clr_mid_count q=%h exp=%h", q, 8'hA5); end
        clr = 1'b0;
        step();
        checks++;
        if (q !== 8'hA6) begin failures++; $display("FAIL cnt_after_clr q=%h exp=%h", q, 8'hA6); end
        // tc independent of en
        do_load(8'hFF);
        mode = MODE_CNT; dir = 1'b1; en = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin failures++; $display("FAIL tc_no_en tc=%b exp=1", tc); end
        step();
        checks++;
        if (q !== 8'hFF) begin failures++; $display("FAIL en_hold_ff q=%h exp=%h", q, 8'hFF); end
    endtask

    initial begin
        clr = 1'b0; en = 1'b0; mode = MODE_JK;
        j = '0; k = '0; d = '0; dir = 1'b0; si = 1'b0;
        test_reset();
        test_jk();
        test_count();
        test_shift();
        test_enable_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
